// File: rtl/kernel_stream_sink.sv
// kernel_stream_sink: responder end of an HLS ap_fifo output stream.
// Buffers accepted words, drains them at a fixed rate, folds each drained
// word into a 4-bit XOR digest and keeps per-run word accounting.
module kernel_stream_sink #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int DRAIN_INV      = 1,
    parameter int STALL_PERIOD   = 0,
    parameter int EXPECTED_WORDS = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic                  ap_done,
    input  logic [DATA_WIDTH-1:0] stream_din,
    input  logic                  stream_write,
    output logic                  stream_full_n,
    output logic [3:0]            data_out,
    output logic                  data_valid,
    output logic [15:0]           word_count,
    output logic                  run_done,
    output logic                  count_err,
    output logic                  drop_err
);

    // state | meaning
    // IDLE  | waiting for ap_start; stream closed
    // RUN   | kernel active; words accepted and counted
    // FLUSH | kernel finished; draining FIFO and output pipeline
    // DONE  | one-cycle end-of-run pulse; word count checked

    localparam int                NBYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] OCC_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_INV - 1);
    localparam logic [15:0]       STALL_LAST = 16'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [15:0]       EXP_C      = 16'(EXPECTED_WORDS);
    localparam bit                STALL_EN   = (STALL_PERIOD > 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]     occ, occ_nxt;
    logic [15:0]             drain_cnt, drain_cnt_nxt;
    logic [15:0]             stall_cnt, stall_cnt_nxt;
    logic                    push, pop, drop, start;
    logic                    stall_nxt, full_n_nxt;
    logic                    valid1;
    logic [7:0]              byte_xor, byte_xor_nxt;

    // Handshake decode, occupancy, rate counters and next-cycle full_n.
    always_comb begin
        push  = stream_write & stream_full_n;
        drop  = stream_write & ~stream_full_n;
        pop   = (drain_cnt == 16'd0) && (occ != '0);
        start = (state == S_IDLE) && ap_start;

        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + OCC_ONE;
        else if (pop && !push)
            occ_nxt = occ - OCC_ONE;

        drain_cnt_nxt = (drain_cnt == DRAIN_LAST) ? 16'd0 : drain_cnt + 16'd1;

        stall_cnt_nxt = 16'd0;
        if (STALL_EN && state == S_RUN)
            stall_cnt_nxt = (stall_cnt == STALL_LAST) ? 16'd0 : stall_cnt + 16'd1;

        state_nxt = state;
        case (state)
            S_IDLE:  if (ap_start) state_nxt = S_RUN;
            S_RUN:   if (ap_done) state_nxt = S_FLUSH;
            // A word accepted on the last FLUSH cycle must still be drained.
            S_FLUSH: if (occ == '0 && !valid1 && !data_valid && !push) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // full_n is a flop, so it is computed from what the registers will hold next cycle.
        stall_nxt  = STALL_EN && (state_nxt == S_RUN) && (stall_cnt_nxt == STALL_LAST);
        full_n_nxt = ((state_nxt == S_RUN) || (state_nxt == S_FLUSH)) &&
                     (occ_nxt != DEPTH_C) && !stall_nxt;

        byte_xor_nxt = 8'h00;
        for (int i = 0; i < NBYTES; i++)
            byte_xor_nxt = byte_xor_nxt ^ mem[rd_ptr][8*i +: 8];
    end

    assign run_done = (state == S_DONE);

    // State register, drain/stall counters and registered full_n.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= S_IDLE;
            drain_cnt     <= '0;
            stall_cnt     <= '0;
            stream_full_n <= 1'b0;
        end else begin
            state         <= state_nxt;
            drain_cnt     <= drain_cnt_nxt;
            stall_cnt     <= stall_cnt_nxt;
            stream_full_n <= full_n_nxt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            occ <= occ_nxt;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr] <= stream_din;
    end

    // Two-stage digest pipeline: byte fold on pop, nibble fold one cycle later.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            valid1     <= 1'b0;
            byte_xor   <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else begin
            valid1     <= pop;
            byte_xor   <= pop ? byte_xor_nxt : byte_xor;
            data_valid <= valid1;
            data_out   <= valid1 ? (byte_xor[7:4] ^ byte_xor[3:0]) : 4'h0;
        end
    end

    // Per-run word accounting and error flags.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            word_count <= '0;
            count_err  <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (start)
                word_count <= '0;
            else if (push && word_count != 16'hFFFF)
                word_count <= word_count + 16'd1;

            if (start)
                count_err <= 1'b0;
            else if (state == S_DONE)
                count_err <= (word_count != EXP_C);

            if (drop)
                drop_err <= 1'b1;
            else if (start)
                drop_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kernel_stream_sink.sv
// Bench for kernel_stream_sink: three instances share one stimulus stream.
//   u_a: DRAIN_INV=1, no stall   u_b: DRAIN_INV=4, no stall   u_c: DRAIN_INV=1, STALL_PERIOD=4
module tb_kernel_stream_sink;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done = 1'b0;
    logic        stream_write = 1'b0;
    logic [31:0] stream_din = '0;

    logic [2:0]  fn, dv, rd, ce, de;
    logic [3:0]  dout [3];
    logic [15:0] wc [3];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc++;

    kernel_stream_sink #(.DRAIN_INV(1), .STALL_PERIOD(0)) u_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .stream_din(stream_din), .stream_write(stream_write), .stream_full_n(fn[0]),
        .data_out(dout[0]), .data_valid(dv[0]), .word_count(wc[0]), .run_done(rd[0]),
        .count_err(ce[0]), .drop_err(de[0]));

    kernel_stream_sink #(.DRAIN_INV(4), .STALL_PERIOD(0)) u_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .stream_din(stream_din), .stream_write(stream_write), .stream_full_n(fn[1]),
        .data_out(dout[1]), .data_valid(dv[1]), .word_count(wc[1]), .run_done(rd[1]),
        .count_err(ce[1]), .drop_err(de[1]));

    kernel_stream_sink #(.DRAIN_INV(1), .STALL_PERIOD(4)) u_c (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .stream_din(stream_din), .stream_write(stream_write), .stream_full_n(fn[2]),
        .data_out(dout[2]), .data_valid(dv[2]), .word_count(wc[2]), .run_done(rd[2]),
        .count_err(ce[2]), .drop_err(de[2]));

    // Output capture
    logic [3:0] q_out0[$], q_out1[$], q_out2[$];
    int t_out1[$];
    int last_dv0 = 0, rd_cyc0 = 0;
    int rd_seen[3] = '{0, 0, 0};

    always @(negedge ap_clk) begin
        if (dv[0]) begin q_out0.push_back(dout[0]); last_dv0 = cyc; end
        if (dv[1]) begin q_out1.push_back(dout[1]); t_out1.push_back(cyc); end
        if (dv[2]) q_out2.push_back(dout[2]);
        if (rd[0]) begin rd_seen[0]++; rd_cyc0 = cyc; end
        if (rd[1]) rd_seen[1]++;
        if (rd[2]) rd_seen[2]++;
    end

    // Strobe log written by drive_run
    logic [31:0] strobe_w[$];
    logic [2:0]  strobe_fn[$];
    int          strobe_k[$];
    int          strobe_cyc[$];

    // Reference digest: XOR of all eight nibbles of the word.
    function automatic logic [3:0] fold(input logic [31:0] w);
        logic [3:0] n = 4'h0;
        for (int i = 0; i < 8; i++) n = n ^ w[4*i +: 4];
        return n;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_capture();
        q_out0.delete(); q_out1.delete(); q_out2.delete(); t_out1.delete();
        rd_seen = '{0, 0, 0};
    endtask

    // One kernel run: start, n write strobes (optionally random data/gaps), then ap_done.
    task automatic drive_run(input int n, input bit rnd_data, input logic [31:0] fixed,
                             input bit rnd_gap, input bit done_last);
        int k = 0;
        int sent = 0;
        strobe_w.delete(); strobe_fn.delete(); strobe_k.delete(); strobe_cyc.delete();
        clear_capture();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        while (sent < n) begin
            if (rnd_gap && $urandom_range(0, 2) == 0) begin
                stream_write = 1'b0;
            end else begin
                stream_din   = rnd_data ? $urandom : fixed;
                stream_write = 1'b1;
                strobe_w.push_back(stream_din);
                strobe_fn.push_back(fn);
                strobe_k.push_back(k);
                strobe_cyc.push_back(cyc);
                sent++;
                if (done_last && sent == n) ap_done = 1'b1;
            end
            tick();
            k++;
        end
        stream_write = 1'b0;
        if (!done_last) begin
            ap_done = 1'b1;
            tick();
        end
        ap_done = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        int n = 0;
        while ((rd_seen[0] == 0 || rd_seen[1] == 0 || rd_seen[2] == 0) && n < 1000) begin
            tick();
            n++;
        end
        ok = (n < 1000);
        tick();
        tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fn[i], dv[i], rd[i], ce[i], de[i], dout[i], wc[i]} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got fn=%b dv=%b rd=%b ce=%b de=%b dout=%h wc=%0d, want all 0",
                         i, fn[i], dv[i], rd[i], ce[i], de[i], dout[i], wc[i]);
            end
        end
        ap_rst = 1'b0;
        tick(); tick();
        n_checks++;
        if (fn !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_full_n: got %b want 000", fn);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        drive_run(64, 1'b0, 32'h0102_0304, 1'b0, 1'b0);
        wait_end(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: run_done not seen, want within 1000 cycles"); end
        n_checks++;
        if (q_out0.size() != 64) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 64", q_out0.size()); end
        for (int j = 0; j < q_out0.size() && j < 64; j++) begin
            n_checks++;
            if (q_out0[j] !== fold(32'h0102_0304)) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %h want %h", j, q_out0[j], fold(32'h0102_0304));
            end
        end
        n_checks++;
        if (wc[0] !== 16'd64) begin n_fail++; $display("FAIL b2b_word_count: got %0d want 64", wc[0]); end
        n_checks++;
        if ({ce[0], de[0]} !== 2'b00) begin n_fail++; $display("FAIL b2b_errs: got ce=%b de=%b want 0 0", ce[0], de[0]); end
        n_checks++;
        if (rd_seen[0] != 1) begin n_fail++; $display("FAIL b2b_run_done: got %0d pulses want 1", rd_seen[0]); end
    endtask

    task automatic test_stall();
        bit ok;
        logic exp_fn;
        logic [3:0] exp_q[$];
        drive_run(64, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_end(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: run_done not seen, want within 1000 cycles"); end
        for (int j = 0; j < strobe_w.size(); j++) begin
            exp_fn = ((strobe_k[j] % 4) != 3);
            if (exp_fn) exp_q.push_back(fold(strobe_w[j]));
            n_checks++;
            if (strobe_fn[j][2] !== exp_fn) begin
                n_fail++;
                $display("FAIL stall_full_n[cycle %0d]: got %b want %b", strobe_k[j], strobe_fn[j][2], exp_fn);
            end
        end
        n_checks++;
        if (wc[2] !== 16'(exp_q.size())) begin n_fail++; $display("FAIL stall_word_count: got %0d want %0d", wc[2], exp_q.size()); end
        n_checks++;
        if (de[2] !== 1'b1) begin n_fail++; $display("FAIL stall_drop_err: got %b want 1", de[2]); end
        n_checks++;
        if (ce[2] !== 1'b1) begin n_fail++; $display("FAIL stall_count_err: got %b want 1", ce[2]); end
        n_checks++;
        if (q_out2 != exp_q) begin n_fail++; $display("FAIL stall_data: got %0d pulses want %0d matching words", q_out2.size(), exp_q.size()); end
    endtask

    task automatic test_drain();
        bit ok;
        logic [3:0] exp_q[$];
        logic exp_drop = 1'b0;
        int fall_cyc = -1;
        int pushes = 0, pops = 0;
        drive_run(64, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_end(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain_timeout: run_done not seen, want within 1000 cycles"); end
        for (int j = 0; j < strobe_w.size(); j++) begin
            if (strobe_fn[j][1]) exp_q.push_back(fold(strobe_w[j]));
            else begin
                exp_drop = 1'b1;
                if (fall_cyc < 0) fall_cyc = strobe_cyc[j];
            end
        end
        n_checks++;
        if (q_out1 != exp_q) begin n_fail++; $display("FAIL drain_order: got %0d pulses want %0d in order", q_out1.size(), exp_q.size()); end
        n_checks++;
        if (wc[1] !== 16'(q_out1.size())) begin n_fail++; $display("FAIL drain_count: word_count %0d, pulses %0d", wc[1], q_out1.size()); end
        n_checks++;
        if (de[1] !== exp_drop) begin n_fail++; $display("FAIL drain_drop_err: got %b want %b", de[1], exp_drop); end
        for (int j = 1; j < t_out1.size(); j++) begin
            n_checks++;
            if (t_out1[j] - t_out1[j-1] != 4) begin
                n_fail++;
                $display("FAIL drain_spacing[%0d]: got %0d cycles want 4", j, t_out1[j] - t_out1[j-1]);
            end
        end
        n_checks++;
        if (fall_cyc < 0) begin
            n_fail++;
            $display("FAIL drain_full_n_fall: got no low full_n want a fall at occupancy 16");
        end else begin
            for (int j = 0; j < strobe_w.size(); j++)
                if (strobe_fn[j][1] && strobe_cyc[j] < fall_cyc) pushes++;
            foreach (t_out1[j]) if (t_out1[j] <= fall_cyc + 1) pops++;
            n_checks++;
            if (pushes - pops != 16) begin
                n_fail++;
                $display("FAIL drain_fall_occupancy: got %0d want 16", pushes - pops);
            end
        end
    endtask

    task automatic test_count_err();
        bit ok;
        drive_run(10, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0);
        wait_end(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL cerr_timeout: run_done not seen, want within 1000 cycles"); end
        n_checks++;
        if (q_out0.size() != 10) begin n_fail++; $display("FAIL cerr_pulses: got %0d want 10", q_out0.size()); end
        foreach (q_out0[j]) begin
            n_checks++;
            if (q_out0[j] !== fold(32'hA5A5_0F0F)) begin
                n_fail++;
                $display("FAIL cerr_data[%0d]: got %h want %h", j, q_out0[j], fold(32'hA5A5_0F0F));
            end
        end
        n_checks++;
        if (wc[0] !== 16'd10) begin n_fail++; $display("FAIL cerr_word_count: got %0d want 10", wc[0]); end
        n_checks++;
        if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL cerr_flag: got %b want 1", ce[0]); end
    endtask

    task automatic test_done_coincident();
        bit ok;
        logic [3:0] exp_q[$];
        drive_run(20, 1'b1, 32'h0, 1'b0, 1'b1);
        wait_end(ok);
        foreach (strobe_w[j]) exp_q.push_back(fold(strobe_w[j]));
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL coinc_timeout: run_done not seen, want within 1000 cycles"); end
        n_checks++;
        if (wc[0] !== 16'd20) begin n_fail++; $display("FAIL coinc_word_count: got %0d want 20", wc[0]); end
        n_checks++;
        if (q_out0 != exp_q) begin n_fail++; $display("FAIL coinc_data: got %0d pulses want 20 in order", q_out0.size()); end
        n_checks++;
        if (rd_cyc0 <= last_dv0) begin n_fail++; $display("FAIL coinc_order: run_done cycle %0d, last data_valid cycle %0d", rd_cyc0, last_dv0); end
        n_checks++;
        if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL coinc_count_err: got %b want 1", ce[0]); end
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] exp_q[$];
        drive_run(64, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_end(ok);
        foreach (strobe_w[j]) exp_q.push_back(fold(strobe_w[j]));
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rand_timeout: run_done not seen, want within 1000 cycles"); end
        n_checks++;
        if (q_out0 != exp_q) begin n_fail++; $display("FAIL rand_data: got %0d pulses want %0d in order", q_out0.size(), exp_q.size()); end
        n_checks++;
        if (wc[0] !== 16'd64) begin n_fail++; $display("FAIL rand_word_count: got %0d want 64", wc[0]); end
        n_checks++;
        if ({ce[0], de[0]} !== 2'b00) begin n_fail++; $display("FAIL rand_errs: got ce=%b de=%b want 0 0", ce[0], de[0]); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        logic [3:0] exp_q[$];
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            stream_din   = $urandom;
            stream_write = 1'b1;
            tick();
        end
        stream_write = 1'b0;
        ap_rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fn[i], dv[i], rd[i], ce[i], de[i], dout[i], wc[i]} !== 25'd0) begin
                n_fail++;
                $display("FAIL midrst_outputs[%0d]: got fn=%b dv=%b wc=%0d dout=%h, want all 0", i, fn[i], dv[i], wc[i], dout[i]);
            end
        end
        clear_capture();
        tick(); tick();
        ap_rst = 1'b0;
        for (int j = 0; j < 30; j++) tick();
        n_checks++;
        if (q_out0.size() + q_out1.size() + q_out2.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d data_valid pulses want 0", q_out0.size() + q_out1.size() + q_out2.size());
        end
        drive_run(5, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_end(ok);
        foreach (strobe_w[j]) exp_q.push_back(fold(strobe_w[j]));
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midrst_timeout: run_done not seen, want within 1000 cycles"); end
        n_checks++;
        if ({wc[0], wc[1]} !== {16'd5, 16'd5}) begin n_fail++; $display("FAIL midrst_word_count: got %0d/%0d want 5/5", wc[0], wc[1]); end
        n_checks++;
        if (q_out1 != exp_q) begin n_fail++; $display("FAIL midrst_data: got %0d pulses want 5 fresh words", q_out1.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_drain();
        test_count_err();
        test_done_coincident();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded 40000 cycles");
        $fatal(1);
    end

endmodule
